mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory-access stage with cache handshake, alignment faults and bus timeout
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        flush_i,
    input  logic [31:0] wb_data,
    input  logic [31:0] data_address,
    input  logic [1:0]  data_cache_control,
    input  logic [1:0]  type_in,
    input  logic [2:0]  fun3,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        dreq_valid,
    input  logic        dreq_ready,
    output logic [31:0] dreq_addr,
    output logic        dreq_we,
    output logic [3:0]  dreq_wstrb,
    output logic [31:0] dreq_wdata,
    input  logic        drsp_valid,
    input  logic [31:0] drsp_data,
    output logic        stall_mem,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_value,
    output logic        misalign,
    output logic        bus_err,
    output logic [31:0] fault_addr
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] REQ  = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Last waiting cycle before the access is abandoned
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [CW-1:0] tcount;
    logic [31:0]   addr_q;
    logic [1:0]    type_q;
    logic          uns_q;
    logic [4:0]    rd_q;

    logic          is_load;
    logic          is_store;
    logic          mis;
    logic          capture;
    logic [3:0]    strb_c;
    logic [31:0]   wdata_c;
    logic [31:0]   lane;
    logic [31:0]   load_val;
    logic          unused_bits;

    assign is_load   = (data_cache_control == 2'b01);
    assign is_store  = (data_cache_control == 2'b10);
    assign capture   = (state == IDLE) && ex_valid && !flush_i;
    assign mis       = (type_in == 2'b11) ||
                       ((type_in == 2'b01) && data_address[0]) ||
                       ((type_in == 2'b10) && (data_address[1:0] != 2'b00));

    assign dreq_valid  = (state == REQ);
    assign stall_mem   = (state != IDLE);
    assign dreq_addr   = {addr_q[31:2], 2'b00};
    assign unused_bits = ^fun3[1:0];

    // Byte-lane strobes and lane-replicated write data for the incoming store
    always_comb begin
        strb_c  = 4'b0000;
        wdata_c = store_data;
        case (type_in)
            2'b00: begin
                strb_c  = 4'b0001 << data_address[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                strb_c  = 4'b0011 << {data_address[1], 1'b0};
                wdata_c = {2{store_data[15:0]}};
            end
            default: begin
                strb_c  = 4'b1111;
                wdata_c = store_data;
            end
        endcase
        if (!is_store) strb_c = 4'b0000;
    end

    // Select the addressed lane of the load response and extend it
    always_comb begin
        lane     = drsp_data >> {addr_q[1:0], 3'b000};
        load_val = lane;
        case (type_q)
            2'b00:   load_val = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_val = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    // Access FSM, timeout counter and registered writeback/fault outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tcount     <= '0;
            addr_q     <= '0;
            type_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            dreq_we    <= 1'b0;
            dreq_wstrb <= '0;
            dreq_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_value   <= '0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            fault_addr <= '0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        if (!(is_load || is_store)) begin
                            wb_valid <= 1'b1;
                            wb_value <= wb_data;
                            wb_rd    <= rd_in;
                        end else if (mis) begin
                            misalign   <= 1'b1;
                            fault_addr <= data_address;
                        end else begin
                            addr_q     <= data_address;
                            type_q     <= type_in;
                            uns_q      <= fun3[2];
                            rd_q       <= rd_in;
                            dreq_we    <= is_store;
                            dreq_wstrb <= strb_c;
                            dreq_wdata <= wdata_c;
                            tcount     <= '0;
                            state      <= REQ;
                        end
                    end
                end
                REQ, RESP: begin
                    if (state == REQ && dreq_ready) begin
                        // Counter keeps running across REQ and RESP of one access
                        state  <= dreq_we ? IDLE : RESP;
                        tcount <= tcount + 1'b1;
                    end else if (state == RESP && drsp_valid) begin
                        wb_valid <= 1'b1;
                        wb_value <= load_val;
                        wb_rd    <= rd_q;
                        state    <= IDLE;
                    end else if (tcount >= T_LAST) begin
                        bus_err    <= 1'b1;
                        fault_addr <= addr_q;
                        state      <= IDLE;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, flush_i;
    logic [31:0] wb_data, data_address, store_data;
    logic [1:0]  data_cache_control, type_in;
    logic [2:0]  fun3;
    logic [4:0]  rd_in;
    logic        dreq_valid, dreq_ready, dreq_we;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_wstrb;
    logic        drsp_valid;
    logic [31:0] drsp_data;
    logic        stall_mem, wb_valid, misalign, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value, fault_addr;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] val;
        logic [4:0]  rd;
    } evt_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    evt_t evq[$];
    req_t rq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .flush_i(flush_i),
        .wb_data(wb_data), .data_address(data_address),
        .data_cache_control(data_cache_control), .type_in(type_in), .fun3(fun3),
        .store_data(store_data), .rd_in(rd_in),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
        .dreq_we(dreq_we), .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
        .drsp_valid(drsp_valid), .drsp_data(drsp_data), .stall_mem(stall_mem),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_value(wb_value),
        .misalign(misalign), .bus_err(bus_err), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ld_model(input logic [1:0] typ, input logic uns,
                                             input logic [1:0] a, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0: b = d[7:0];
            2'd1: b = d[15:8];
            2'd2: b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        if (typ == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
        if (typ == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
        return d;
    endfunction

    function automatic logic [3:0] strb_model(input logic [1:0] typ, input logic [1:0] a);
        if (typ == 2'b10) return 4'hF;
        if (typ == 2'b01) return a[1] ? 4'hC : 4'h3;
        case (a)
            2'd0: return 4'h1;
            2'd1: return 4'h2;
            2'd2: return 4'h4;
            default: return 4'h8;
        endcase
    endfunction

    function automatic logic [31:0] wdata_model(input logic [1:0] typ, input logic [31:0] sd);
        if (typ == 2'b00) return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
        if (typ == 2'b01) return {sd[15:0], sd[15:0]};
        return sd;
    endfunction

    // Output monitor: compares writeback/fault pulses and bus requests against the queues
    always @(negedge clk) begin
        if (rst_n && (wb_valid || misalign || bus_err)) begin
            if (evq.size() == 0) begin
                check_eq("unexpected_event", 32'd1, 32'd0);
            end else begin
                evt_t e;
                e = evq.pop_front();
                check_eq("evt_kind", wb_valid ? 32'd0 : (misalign ? 32'd1 : 32'd2), {30'd0, e.kind});
                check_eq("evt_stall", {31'd0, stall_mem}, 32'd0);
                if (e.kind == 2'd0) begin
                    check_eq("wb_value", wb_value, e.val);
                    check_eq("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                end else begin
                    check_eq("fault_addr", fault_addr, e.val);
                end
            end
        end
        if (rst_n && dreq_valid) begin
            if (rq.size() == 0) begin
                check_eq("unexpected_req", 32'd1, 32'd0);
            end else begin
                check_eq("dreq_addr", dreq_addr, rq[0].addr);
                if (dreq_ready) begin
                    req_t r;
                    r = rq.pop_front();
                    check_eq("dreq_we", {31'd0, dreq_we}, {31'd0, r.we});
                    if (r.we) begin
                        check_eq("dreq_wstrb", {28'd0, dreq_wstrb}, {28'd0, r.strb});
                        check_eq("dreq_wdata", dreq_wdata, r.wdata);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] ctl, input logic [1:0] typ, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] wbd,
                         input logic [4:0] rd, input logic fl);
        @(posedge clk); #1;
        ex_valid = 1'b1; flush_i = fl; data_cache_control = ctl; type_in = typ;
        fun3 = f3; data_address = addr; store_data = sd; wb_data = wbd; rd_in = rd;
        @(posedge clk); #1;
        ex_valid = 1'b0; flush_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && (evq.size() != 0 || rq.size() != 0); i++) begin
            @(negedge clk); #1;
        end
        check_eq(tag, evq.size() + rq.size(), 32'd0);
    endtask

    task automatic mem_op(input logic [1:0] ctl, input logic [1:0] typ, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                          input int ready_dly, input logic [31:0] rdata);
        req_t r;
        evt_t e;
        r.addr = {addr[31:2], 2'b00};
        r.we = (ctl == 2'b10);
        r.strb = strb_model(typ, addr[1:0]);
        r.wdata = wdata_model(typ, sd);
        rq.push_back(r);
        if (ctl == 2'b01) begin
            e.kind = 2'd0; e.val = ld_model(typ, f3[2], addr[1:0], rdata); e.rd = rd;
            evq.push_back(e);
        end
        issue(ctl, typ, f3, addr, sd, 32'h0, rd, 1'b0);
        for (int i = 0; i < 20 && !dreq_valid; i++) @(negedge clk);
        check_eq("req_seen", {31'd0, dreq_valid}, 32'd1);
        repeat (ready_dly) @(posedge clk);
        #1 dreq_ready = 1'b1;
        @(posedge clk); #1 dreq_ready = 1'b0;
        if (ctl == 2'b01) begin
            @(posedge clk); #1 drsp_valid = 1'b1; drsp_data = rdata;
            @(posedge clk); #1 drsp_valid = 1'b0; drsp_data = 32'h0;
        end
        drain("mem_op_done");
    endtask

    task automatic misalign_op(input logic [1:0] ctl, input logic [1:0] typ, input logic [31:0] addr);
        evt_t e;
        e.kind = 2'd1; e.val = addr; e.rd = 5'd0;
        evq.push_back(e);
        dreq_ready = 1'b1;
        issue(ctl, typ, 3'b010, addr, 32'hDEAD_BEEF, 32'h0, 5'd9, 1'b0);
        repeat (3) @(posedge clk);
        #1 dreq_ready = 1'b0;
        drain("misalign_done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        evt_t e;
        req_t r;
        int   cnt;
        rst_n = 1'b0; ex_valid = 1'b0; flush_i = 1'b0; wb_data = '0; data_address = '0;
        data_cache_control = '0; type_in = '0; fun3 = '0; store_data = '0; rd_in = '0;
        dreq_ready = 1'b0; drsp_valid = 1'b0; drsp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_stall", {31'd0, stall_mem}, 32'd0);
        check_eq("rst_dreq_valid", {31'd0, dreq_valid}, 32'd0);
        check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        rst_n = 1'b1;

        // ALU op writeback
        e.kind = 2'd0; e.val = 32'h1234_5678; e.rd = 5'd5;
        evq.push_back(e);
        issue(2'b00, 2'b10, 3'b000, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b0);
        drain("alu_done");

        // Flushed op and stray response while idle produce nothing
        issue(2'b01, 2'b10, 3'b010, 32'h40, 32'h0, 32'h0, 5'd3, 1'b1);
        issue(2'b00, 2'b10, 3'b000, 32'h0, 32'h0, 32'h55, 5'd4, 1'b1);
        #1 drsp_valid = 1'b1; drsp_data = 32'h1;
        @(posedge clk); #1 drsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("flush_stall", {31'd0, stall_mem}, 32'd0);
        drain("flush_done");

        // LB / LBU with delayed ready
        mem_op(2'b01, 2'b00, 3'b000, 32'h103, 32'h0, 5'd7, 3, 32'h80FF_FF7F);
        mem_op(2'b01, 2'b00, 3'b100, 32'h103, 32'h0, 5'd8, 3, 32'h80FF_FF7F);
        // SH
        mem_op(2'b10, 2'b01, 3'b001, 32'h202, 32'hAAAA_BEEF, 5'd0, 0, 32'h0);

        // Misaligned accesses
        misalign_op(2'b01, 2'b10, 32'h301);
        misalign_op(2'b01, 2'b01, 32'h211);
        misalign_op(2'b10, 2'b11, 32'h300);

        // Random aligned loads/stores against the model
        for (int k = 0; k < 8; k++) begin
            logic [1:0]  typ;
            logic [1:0]  off;
            logic [31:0] a;
            typ = 2'($urandom_range(0, 2));
            off = 2'($urandom_range(0, 3));
            if (typ == 2'b01) off[0] = 1'b0;
            if (typ == 2'b10) off = 2'b00;
            a = {20'h0, 10'($urandom), off};
            mem_op(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, typ,
                   {1'($urandom_range(0, 1)), 2'b00}, a, $urandom, 5'($urandom_range(1, 31)),
                   $urandom_range(0, 2), $urandom);
        end

        // Timeout: load accepted but never answered
        r.addr = 32'h400; r.we = 1'b0; r.strb = 4'h0; r.wdata = 32'h0;
        rq.push_back(r);
        e.kind = 2'd2; e.val = 32'h400; e.rd = 5'd0;
        evq.push_back(e);
        dreq_ready = 1'b1;
        issue(2'b01, 2'b10, 3'b010, 32'h400, 32'h0, 32'h0, 5'd10, 1'b0);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!stall_mem) break;
            cnt++;
        end
        check_eq("timeout_stall_cycles", cnt, 32'd255);
        #1 dreq_ready = 1'b0;
        drain("timeout_done");

        // Reset during RESP of another load
        r.addr = 32'h500; r.we = 1'b0; r.strb = 4'h0; r.wdata = 32'h0;
        rq.push_back(r);
        dreq_ready = 1'b1;
        issue(2'b01, 2'b10, 3'b010, 32'h500, 32'h0, 32'h0, 5'd11, 1'b0);
        @(posedge clk); #1 dreq_ready = 1'b0;
        check_eq("pre_rst_stall", {31'd0, stall_mem}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_stall", {31'd0, stall_mem}, 32'd0);
        check_eq("rst_mid_dreq_valid", {31'd0, dreq_valid}, 32'd0);
        check_eq("rst_mid_dreq_addr", dreq_addr, 32'd0);
        check_eq("rst_mid_wb_value", wb_value, 32'd0);
        check_eq("rst_mid_fault_addr", fault_addr, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        drsp_valid = 1'b1; drsp_data = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #1 drsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_stall", {31'd0, stall_mem}, 32'd0);
        drain("post_rst_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
